// File: rtl/acc_pkg.sv
// Shared definitions for the grouped product accumulator.
//   - default widths, result record layout
//   - saturation bound helpers (valid for widths up to 64 bits)
//   - group length decode (0 or oversize request means "use the maximum")
package acc_pkg;

  localparam int unsigned DataWDef  = 32;
  localparam int unsigned AccWDef   = 32;
  localparam int unsigned MaxLenDef = 16;
  localparam int unsigned CntWDef   = $clog2(MaxLenDef + 1);

  // Result record as stored in the output buffer, at default widths.
  typedef struct packed {
    logic [AccWDef-1:0] sum;
    logic               ovf;
    logic [CntWDef-1:0] cnt;
  } acc_result_t;

  // Largest positive value of a w-bit signed number, zero-extended to 64 bits.
  function automatic logic [63:0] sat_max(int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit signed value; only the low w bits are meaningful.
  function automatic logic [63:0] sat_min(int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic int unsigned len_decode(int unsigned cfg, int unsigned max_len);
    if (cfg == 0 || cfg > max_len) return max_len;
    return cfg;
  endfunction

endpackage

// File: rtl/acc_result_fifo.sv
// Small synchronous first-word-fall-through FIFO holding finished group results.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset, empties the FIFO
//   push_i  : write data_i (ignored while full)
//   data_i  : entry to write
//   pop_i   : drop head entry (ignored while empty)
//   data_o  : head entry, valid while !empty_o
//   full_o  : registered full flag
//   empty_o : registered empty flag
module acc_result_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    full_d   = full_q;
    empty_d  = empty_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = (wr_ptr_q + AW'(1)) == rd_ptr_q;
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = (rd_ptr_q + AW'(1)) == wr_ptr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only visible behind empty_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/accumulate_group.sv
// Sums runtime-length groups of signed products with optional saturation and
// early flush, delivering {sum, ovf, cnt} through a small valid/ready buffer.
//   clk, rst              : clock, asynchronous active-high reset
//   len_cfg               : terms per group (0 or > MAX_LEN means MAX_LEN)
//   mult_valid/data/ready : product input handshake
//   flush                 : close the open group early
//   data_out/ovf_out/cnt_out/valid_out/ready_out : result handshake (FWFT)
module accumulate_group
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W    = DataWDef,
  parameter int unsigned ACC_W     = AccWDef,
  parameter int unsigned MAX_LEN   = MaxLenDef,
  parameter bit          SATURATE  = 1'b1,
  parameter int unsigned OUT_DEPTH = 2,
  localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  len_cfg,
  input  logic              mult_valid,
  input  logic [DATA_W-1:0] mult_data,
  output logic              mult_ready,
  input  logic              flush,
  output logic [ACC_W-1:0]  data_out,
  output logic              ovf_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              valid_out,
  input  logic              ready_out
);

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } res_t;

  localparam logic [ACC_W-1:0] SatMax = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SatMin = ACC_W'(sat_min(ACC_W));

  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;

  logic             accept, flush_ok, push, full, empty;
  logic [CNT_W-1:0] len_eff, len_cur, cnt_inc;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_new;
  logic             ovf_now;
  res_t             push_data, head;

  assign mult_ready = ~full;
  assign accept     = mult_valid & ~full;
  assign flush_ok   = flush & ~full;

  always_comb begin
    len_eff = CNT_W'(len_decode(int'(len_cfg), MAX_LEN));
    // Length is latched on the first term, so only a fresh group sees len_cfg.
    len_cur = (cnt_q == '0) ? len_eff : len_q;
    cnt_inc = cnt_q + CNT_W'(1);

    // One guard bit: the true sum leaves the ACC_W range iff the top two bits differ.
    sum_wide = {sum_q[ACC_W-1], sum_q}
             + {{(ACC_W + 1 - DATA_W){mult_data[DATA_W-1]}}, mult_data};
    ovf_now  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (SATURATE && ovf_now) sum_new = sum_wide[ACC_W] ? SatMin : SatMax;
    else                     sum_new = sum_wide[ACC_W-1:0];

    push = (accept && (cnt_inc == len_cur || flush_ok))
        || (flush_ok && !accept && cnt_q != '0);

    if (accept) push_data = '{sum: sum_new, ovf: ovf_q | ovf_now, cnt: cnt_inc};
    else        push_data = '{sum: sum_q, ovf: ovf_q, cnt: cnt_q};

    sum_d = sum_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    len_d = (accept && cnt_q == '0) ? len_eff : len_q;
    if (push) begin
      sum_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (accept) begin
      sum_d = sum_new;
      ovf_d = ovf_q | ovf_now;
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  acc_result_fifo #(
    .Width ($bits(res_t)),
    .Depth (OUT_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (ready_out),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Mask the head so outputs read zero while nothing is buffered.
  assign valid_out = ~empty;
  assign data_out  = empty ? '0 : head.sum;
  assign ovf_out   = ~empty & head.ovf;
  assign cnt_out   = empty ? '0 : head.cnt;

endmodule

// File: tb/tb_accumulate_group.sv
module tb_accumulate_group;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  len_cfg;
  logic        mult_valid;
  logic [31:0] mult_data;
  logic        flush;
  logic        ready_out;

  logic        mult_ready, ovf_out, valid_out;
  logic [31:0] data_out;
  logic [4:0]  cnt_out;
  logic        w_mult_ready, w_ovf_out, w_valid_out;
  logic [31:0] w_data_out;
  logic [4:0]  w_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  accumulate_group #(.SATURATE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .len_cfg    (len_cfg),
    .mult_valid (mult_valid),
    .mult_data  (mult_data),
    .mult_ready (mult_ready),
    .flush      (flush),
    .data_out   (data_out),
    .ovf_out    (ovf_out),
    .cnt_out    (cnt_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out)
  );

  accumulate_group #(.SATURATE(1'b0)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .len_cfg    (len_cfg),
    .mult_valid (mult_valid),
    .mult_data  (mult_data),
    .mult_ready (w_mult_ready),
    .flush      (flush),
    .data_out   (w_data_out),
    .ovf_out    (w_ovf_out),
    .cnt_out    (w_cnt_out),
    .valid_out  (w_valid_out),
    .ready_out  (ready_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] v);
    mult_valid = 1'b1;
    mult_data  = v;
    tick();
    mult_valid = 1'b0;
  endtask

  task automatic pop_one();
    ready_out = 1'b1;
    tick();
    ready_out = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; len_cfg = 5'd0; mult_valid = 1'b0; mult_data = '0; flush = 1'b0;
    ready_out = 1'b0;
    tick(); tick();
    n_tests++;
    if ({valid_out, data_out, ovf_out, cnt_out, mult_ready} !== {1'b0, 32'd0, 1'b0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: v=%b d=%h o=%b c=%0d r=%b, want v=0 d=0 o=0 c=0 r=1",
               valid_out, data_out, ovf_out, cnt_out, mult_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_len15();
    len_cfg = 5'd15;
    for (int i = 0; i < 14; i++) feed(32'd1);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL len15_early: valid_out=%b want 0", valid_out);
    end
    feed(32'd1);
    n_tests++;
    if ({valid_out, data_out, ovf_out, cnt_out} !== {1'b1, 32'd15, 1'b0, 5'd15}) begin
      n_fail++;
      $display("FAIL len15: v=%b d=%0d o=%b c=%0d, want v=1 d=15 o=0 c=15",
               valid_out, data_out, ovf_out, cnt_out);
    end
    pop_one();
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL len15_pop: valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_saturate();
    len_cfg = 5'd3;
    feed(32'h7FFF_FFFF); feed(32'd1); feed(32'd1);
    n_tests++;
    if ({valid_out, data_out, ovf_out, cnt_out} !== {1'b1, 32'h7FFF_FFFF, 1'b1, 5'd3}) begin
      n_fail++;
      $display("FAIL sat: v=%b d=%h o=%b c=%0d, want v=1 d=7fffffff o=1 c=3",
               valid_out, data_out, ovf_out, cnt_out);
    end
    n_tests++;
    if ({w_valid_out, w_data_out, w_ovf_out, w_cnt_out} !== {1'b1, 32'h8000_0001, 1'b1, 5'd3}) begin
      n_fail++;
      $display("FAIL wrap: v=%b d=%h o=%b c=%0d, want v=1 d=80000001 o=1 c=3",
               w_valid_out, w_data_out, w_ovf_out, w_cnt_out);
    end
    pop_one();
  endtask

  task automatic test_flush();
    len_cfg = 5'd4;
    feed(32'd5); feed(-32'sd7);
    flush = 1'b1; tick(); flush = 1'b0;
    n_tests++;
    if ({valid_out, data_out, ovf_out, cnt_out} !== {1'b1, 32'hFFFF_FFFE, 1'b0, 5'd2}) begin
      n_fail++;
      $display("FAIL flush_partial: v=%b d=%h o=%b c=%0d, want v=1 d=fffffffe o=0 c=2",
               valid_out, data_out, ovf_out, cnt_out);
    end
    pop_one();
    feed(32'd5); feed(-32'sd7);
    flush = 1'b1; feed(32'd9); flush = 1'b0;
    n_tests++;
    if ({valid_out, data_out, ovf_out, cnt_out} !== {1'b1, 32'd7, 1'b0, 5'd3}) begin
      n_fail++;
      $display("FAIL flush_accept: v=%b d=%0d o=%b c=%0d, want v=1 d=7 o=0 c=3",
               valid_out, data_out, ovf_out, cnt_out);
    end
    pop_one();
    // Flush on an empty group must not create a result.
    flush = 1'b1; tick(); flush = 1'b0;
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty: valid_out=%b want 0", valid_out);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] terms [4];
    logic [31:0] got [$];
    int idx;
    terms[0] = 32'd11; terms[1] = 32'd22; terms[2] = 32'd33; terms[3] = 32'd44;
    len_cfg = 5'd1; ready_out = 1'b0;
    feed(terms[0]); feed(terms[1]);
    mult_valid = 1'b1; mult_data = terms[2];
    n_tests++;
    if ({mult_ready, valid_out, data_out} !== {1'b0, 1'b1, 32'd11}) begin
      n_fail++;
      $display("FAIL bp_full: r=%b v=%b d=%0d, want r=0 v=1 d=11", mult_ready, valid_out, data_out);
    end
    tick(); tick();
    n_tests++;
    if ({mult_ready, data_out} !== {1'b0, 32'd11}) begin
      n_fail++;
      $display("FAIL bp_stall: r=%b d=%0d, want r=0 d=11", mult_ready, data_out);
    end
    idx = 2;
    ready_out = 1'b1;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      logic acc;
      if (valid_out) got.push_back(data_out);
      acc = mult_valid & mult_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) mult_data = terms[idx];
        else mult_valid = 1'b0;
      end
    end
    mult_valid = 1'b0; ready_out = 1'b0;
    n_tests++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d results want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (got[i] !== terms[i]) begin
          n_fail++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], terms[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    int stalls = 0;
    len_cfg = 5'd1; ready_out = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        mult_valid = 1'b1; mult_data = 32'(i + 1);
        if (!mult_ready) stalls++;
      end else begin
        mult_valid = 1'b0;
      end
      if (valid_out) got.push_back(data_out);
      tick();
    end
    mult_valid = 1'b0; ready_out = 1'b0;
    n_tests++;
    if (stalls != 0 || got.size() != 5) begin
      n_fail++; $display("FAIL b2b_rate: stalls=%0d results=%0d want 0 and 5", stalls, got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (got[i] !== 32'(i + 1)) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, got[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_len_change();
    len_cfg = 5'd4;
    feed(32'd1);
    len_cfg = 5'd2;
    feed(32'd1); feed(32'd1);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL lenchg_hold: valid_out=%b want 0", valid_out);
    end
    feed(32'd1);
    n_tests++;
    if ({valid_out, data_out, cnt_out} !== {1'b1, 32'd4, 5'd4}) begin
      n_fail++;
      $display("FAIL lenchg_old: v=%b d=%0d c=%0d, want v=1 d=4 c=4", valid_out, data_out, cnt_out);
    end
    pop_one();
    feed(32'd3); feed(32'd4);
    n_tests++;
    if ({valid_out, data_out, cnt_out} !== {1'b1, 32'd7, 5'd2}) begin
      n_fail++;
      $display("FAIL lenchg_new: v=%b d=%0d c=%0d, want v=1 d=7 c=2", valid_out, data_out, cnt_out);
    end
    pop_one();
  endtask

  task automatic test_reset_mid();
    len_cfg = 5'd5;
    feed(32'd10); feed(32'd10); feed(32'd10);
    rst = 1'b1;
    #2;
    n_tests++;
    if ({valid_out, data_out, ovf_out, cnt_out, mult_ready} !== {1'b0, 32'd0, 1'b0, 5'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_mid: v=%b d=%0d o=%b c=%0d r=%b, want v=0 d=0 o=0 c=0 r=1",
               valid_out, data_out, ovf_out, cnt_out, mult_ready);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) feed(32'd1);
    n_tests++;
    if (valid_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_regroup_early: valid_out=%b want 0", valid_out);
    end
    feed(32'd1);
    n_tests++;
    if ({valid_out, data_out, ovf_out, cnt_out} !== {1'b1, 32'd5, 1'b0, 5'd5}) begin
      n_fail++;
      $display("FAIL rst_regroup: v=%b d=%0d o=%b c=%0d, want v=1 d=5 o=0 c=5",
               valid_out, data_out, ovf_out, cnt_out);
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_len15();
    test_saturate();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_len_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
